home_time_keeper: RTL and testbench
===================================

Name: home_time_keeper

Overview:
Time-of-day source for the home automation controllers. It divides the system clock down to 1 s ticks and keeps hour/minute/second and day-of-week counters. Its hour/minute outputs drive the schedulers (robot vacuum, pet feeder) and the thermostat time_of_day input. It also produces aligned tick pulses and has a validated set-time handshake for the app/RTC sync path.

Parameters:
TICKS_PER_SEC, 32768, clk cycles per second; legal range 1..65535.
PRESCALE_W, 16, prescaler counter width; must hold TICKS_PER_SEC-1.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  1 = timekeeping runs; 0 = prescaler and time frozen
set_valid  in  1  set request valid
set_hour  in  5  requested hour, legal 0..23
set_minute  in  6  requested minute, legal 0..59
set_second  in  6  requested second, legal 0..59
set_day  in  3  requested day of week, legal 0..6
set_ready  out  1  block can accept a set request
set_done  out  1  one-cycle pulse: request applied
set_error  out  1  one-cycle pulse: request rejected (out of range)
hour  out  5  current hour 0..23
minute  out  6  current minute 0..59
second  out  6  current second 0..59
day_of_week  out  3  current day 0..6
sec_tick  out  1  one-cycle pulse on each second advance
min_tick  out  1  one-cycle pulse when minute changes by rollover
hour_tick  out  1  one-cycle pulse when hour changes by rollover
day_tick  out  1  one-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset (rst_n low, async, effective immediately):
  - prescaler, hour, minute, second and day_of_week = 0.
  - all tick pulses, set_done and set_error = 0.
  - FSM = IDLE, so set_ready = 1.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while enable=1 and FSM=IDLE; otherwise holds.
  - At terminal count it wraps to 0 and the time advances on that same edge.
- Advance:
  - second +1. At 59 it wraps to 0 and minute +1.
  - At minute 59 the minute wraps and hour +1.
  - At hour 23 the hour wraps to 0 and day_of_week +1 (6 -> 0).
- Tick timing:
  - Ticks are registered and go high in the same cycle the new time values first appear.
  - min_tick, hour_tick and day_tick are asserted only together with sec_tick, and each implies the ones below it.
- set_ready = (state == IDLE). The FSM has two states, IDLE and APPLY.
- IDLE:
  - On set_valid && set_ready, capture all four set fields into holding registers and go to APPLY.
  - The capture cycle is a normal cycle: if a tick is due it occurs, and the captured values are unaffected.
- APPLY (exactly one cycle, set_ready = 0):
  - Prescaler and time hold and no tick fires, even if the terminal count is reached.
  - Check hour<=23, minute<=59, second<=59, day<=6.
  - All legal: load the four counters, clear the prescaler to 0, pulse set_done on the following cycle.
  - Any field illegal: counters and prescaler unchanged, pulse set_error on the following cycle.
  - Return to IDLE either way.
- set_done/set_error assert in the first IDLE cycle after APPLY and are never high together.
- The set path does not depend on enable: sets are accepted and applied while frozen.
- set_valid held high across APPLY → a new request is captured in the next IDLE cycle (back-to-back sets are 2 cycles apart).
- Loaded values generate no ticks.
- Reset during APPLY aborts the request: the FSM returns to IDLE with all outputs at their reset values.
- Arithmetic: all counters are unsigned, with explicit compare-and-wrap and no modulo operators. The prescaler compare is against TICKS_PER_SEC-1, truncated to PRESCALE_W.

Test Plan:
- rst_n low mid-count (TICKS_PER_SEC=4, time 00:00:03) -> all time outputs 0 within the same cycle without a clock edge, no ticks, set_ready=1.
- Free run, TICKS_PER_SEC=4, enable=1 from reset -> second=1 with sec_tick high for 1 cycle after 4 clocks. After 240 clocks, minute=1 and second=0 with sec_tick and min_tick coincident.
- Set 23:59:58 day 6 (legal) -> set_ready low for 1 cycle, then set_done pulse with outputs 23:59:58/6. 8 clocks later outputs read 00:00:00/0, with sec/min/hour/day ticks all high in that one cycle.
- Set hour=24, minute=10 -> set_error pulse, set_done stays 0, time unchanged. Free-running counting resumes after APPLY with the prescaler phase preserved.
- enable=0 for 10 clocks with the prescaler at 2 -> no output change and no ticks. After re-enable, the next sec_tick arrives 2 clocks later (prescaler resumes at 2).
- set_valid on the terminal prescaler cycle with set 10:00:00 -> sec_tick fires in the capture cycle, APPLY then loads 10:00:00, and the next sec_tick comes 4 clocks after set_done. A vacuum scheduler on hour/minute sees 10:00.

Source files
------------

// File: rtl/home_time_keeper.sv
// Time-of-day keeper: divides clk down to 1 s ticks and keeps hh:mm:ss plus day of week.
// Includes a two-state set handshake that validates requested values before loading them.
module home_time_keeper #(
   parameter int unsigned TICKS_PER_SEC = 32768,
   parameter int unsigned PRESCALE_W    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       set_valid,
   input  logic [4:0] set_hour,
   input  logic [5:0] set_minute,
   input  logic [5:0] set_second,
   input  logic [2:0] set_day,
   output logic       set_ready,
   output logic       set_done,
   output logic       set_error,
   output logic [4:0] hour,
   output logic [5:0] minute,
   output logic [5:0] second,
   output logic [2:0] day_of_week,
   output logic       sec_tick,
   output logic       min_tick,
   output logic       hour_tick,
   output logic       day_tick
);

   localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(TICKS_PER_SEC - 1);

   typedef enum logic [0:0] {StIdle, StApply} state_e;

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [4:0]            hour_q, hour_d;
   logic [5:0]            minute_q, minute_d;
   logic [5:0]            second_q, second_d;
   logic [2:0]            day_q, day_d;
   logic [4:0]            hold_hour_q, hold_hour_d;
   logic [5:0]            hold_minute_q, hold_minute_d;
   logic [5:0]            hold_second_q, hold_second_d;
   logic [2:0]            hold_day_q, hold_day_d;
   logic                  sec_tick_q, sec_tick_d;
   logic                  min_tick_q, min_tick_d;
   logic                  hour_tick_q, hour_tick_d;
   logic                  day_tick_q, day_tick_d;
   logic                  set_done_q, set_done_d;
   logic                  set_error_q, set_error_d;

   logic                  sec_wrap, min_wrap, hour_wrap, day_wrap;
   logic [5:0]            second_inc, minute_inc;
   logic [4:0]            hour_inc;
   logic [2:0]            day_inc;
   logic                  hold_legal;

   // Explicit compare-and-wrap for each counter.
   always_comb begin
      sec_wrap   = (second_q == 6'd59);
      min_wrap   = (minute_q == 6'd59);
      hour_wrap  = (hour_q == 5'd23);
      day_wrap   = (day_q == 3'd6);
      second_inc = sec_wrap ? 6'd0 : second_q + 6'd1;
      minute_inc = min_wrap ? 6'd0 : minute_q + 6'd1;
      hour_inc   = hour_wrap ? 5'd0 : hour_q + 5'd1;
      day_inc    = day_wrap ? 3'd0 : day_q + 3'd1;
      hold_legal = (hold_hour_q <= 5'd23) && (hold_minute_q <= 6'd59) &&
                   (hold_second_q <= 6'd59) && (hold_day_q <= 3'd6);
   end

   always_comb begin
      state_d       = state_q;
      prescale_d    = prescale_q;
      hour_d        = hour_q;
      minute_d      = minute_q;
      second_d      = second_q;
      day_d         = day_q;
      hold_hour_d   = hold_hour_q;
      hold_minute_d = hold_minute_q;
      hold_second_d = hold_second_q;
      hold_day_d    = hold_day_q;
      sec_tick_d    = 1'b0;
      min_tick_d    = 1'b0;
      hour_tick_d   = 1'b0;
      day_tick_d    = 1'b0;
      set_done_d    = 1'b0;
      set_error_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (enable) begin
               if (prescale_q == PRESCALE_MAX) begin
                  prescale_d = '0;
                  second_d   = second_inc;
                  sec_tick_d = 1'b1;
                  if (sec_wrap) begin
                     minute_d   = minute_inc;
                     min_tick_d = 1'b1;
                     if (min_wrap) begin
                        hour_d      = hour_inc;
                        hour_tick_d = 1'b1;
                        if (hour_wrap) begin
                           day_d      = day_inc;
                           day_tick_d = 1'b1;
                        end
                     end
                  end
               end else begin
                  prescale_d = prescale_q + PRESCALE_W'(1);
               end
            end
            // Capture is independent of the tick above; both may happen on the same edge.
            if (set_valid) begin
               hold_hour_d   = set_hour;
               hold_minute_d = set_minute;
               hold_second_d = set_second;
               hold_day_d    = set_day;
               state_d       = StApply;
            end
         end
         StApply: begin
            state_d = StIdle;
            if (hold_legal) begin
               hour_d     = hold_hour_q;
               minute_d   = hold_minute_q;
               second_d   = hold_second_q;
               day_d      = hold_day_q;
               prescale_d = '0;
               set_done_d = 1'b1;
            end else begin
               set_error_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         prescale_q    <= '0;
         hour_q        <= '0;
         minute_q      <= '0;
         second_q      <= '0;
         day_q         <= '0;
         hold_hour_q   <= '0;
         hold_minute_q <= '0;
         hold_second_q <= '0;
         hold_day_q    <= '0;
         sec_tick_q    <= 1'b0;
         min_tick_q    <= 1'b0;
         hour_tick_q   <= 1'b0;
         day_tick_q    <= 1'b0;
         set_done_q    <= 1'b0;
         set_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         prescale_q    <= prescale_d;
         hour_q        <= hour_d;
         minute_q      <= minute_d;
         second_q      <= second_d;
         day_q         <= day_d;
         hold_hour_q   <= hold_hour_d;
         hold_minute_q <= hold_minute_d;
         hold_second_q <= hold_second_d;
         hold_day_q    <= hold_day_d;
         sec_tick_q    <= sec_tick_d;
         min_tick_q    <= min_tick_d;
         hour_tick_q   <= hour_tick_d;
         day_tick_q    <= day_tick_d;
         set_done_q    <= set_done_d;
         set_error_q   <= set_error_d;
      end
   end

   assign set_ready   = (state_q == StIdle);
   assign set_done    = set_done_q;
   assign set_error   = set_error_q;
   assign hour        = hour_q;
   assign minute      = minute_q;
   assign second      = second_q;
   assign day_of_week = day_q;
   assign sec_tick    = sec_tick_q;
   assign min_tick    = min_tick_q;
   assign hour_tick   = hour_tick_q;
   assign day_tick    = day_tick_q;

endmodule

// File: tb/tb_home_time_keeper.sv
// Randomized bench for home_time_keeper against a seconds-of-week reference model,
// plus directed scenarios with literal expectations.
module tb_home_time_keeper;

   localparam int TPS  = 4;
   localparam int WEEK = 7 * 86400;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       set_valid = 1'b0;
   logic [4:0] set_hour = '0;
   logic [5:0] set_minute = '0;
   logic [5:0] set_second = '0;
   logic [2:0] set_day = '0;
   logic       set_ready, set_done, set_error;
   logic [4:0] hour;
   logic [5:0] minute, second;
   logic [2:0] day_of_week;
   logic       sec_tick, min_tick, hour_tick, day_tick;

   int n_checks = 0;
   int n_err = 0;

   home_time_keeper #(.TICKS_PER_SEC(TPS), .PRESCALE_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .set_valid(set_valid),
      .set_hour(set_hour), .set_minute(set_minute), .set_second(set_second),
      .set_day(set_day), .set_ready(set_ready), .set_done(set_done),
      .set_error(set_error), .hour(hour), .minute(minute), .second(second),
      .day_of_week(day_of_week), .sec_tick(sec_tick), .min_tick(min_tick),
      .hour_tick(hour_tick), .day_tick(day_tick)
   );

   always #5 clk = ~clk;

   // Model: time as seconds since start of week, phase as clocks into the current second.
   typedef struct packed {
      int t;
      int phase;
      bit pend;
      int h;
      int mi;
      int s;
      int d;
      bit done;
      bit err;
      bit st;
      bit mt;
      bit ht;
      bit dt;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r = '0;
      return r;
   endfunction

   function automatic model_t model_step(model_t c, logic en, logic sv, logic [4:0] sh,
                                         logic [5:0] sm, logic [5:0] ss, logic [2:0] sd);
      model_t n;
      n      = c;
      n.done = 1'b0;
      n.err  = 1'b0;
      n.st   = 1'b0;
      n.mt   = 1'b0;
      n.ht   = 1'b0;
      n.dt   = 1'b0;
      if (c.pend) begin
         n.pend = 1'b0;
         if (c.h < 24 && c.mi < 60 && c.s < 60 && c.d < 7) begin
            n.t     = c.d * 86400 + c.h * 3600 + c.mi * 60 + c.s;
            n.phase = 0;
            n.done  = 1'b1;
         end else begin
            n.err = 1'b1;
         end
      end else begin
         if (en) begin
            if (c.phase == TPS - 1) begin
               n.phase = 0;
               n.t     = (c.t + 1) % WEEK;
               n.st    = 1'b1;
               n.mt    = (n.t % 60 == 0);
               n.ht    = (n.t % 3600 == 0);
               n.dt    = (n.t % 86400 == 0);
            end else begin
               n.phase = c.phase + 1;
            end
         end
         if (sv) begin
            n.pend = 1'b1;
            n.h    = int'(sh);
            n.mi   = int'(sm);
            n.s    = int'(ss);
            n.d    = int'(sd);
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else m <= model_step(m, enable, set_valid, set_hour, set_minute, set_second, set_day);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("time", 32'({hour, minute, second, day_of_week}),
            32'({5'((m.t / 3600) % 24), 6'((m.t / 60) % 60), 6'(m.t % 60), 3'(m.t / 86400)}));
      check("ticks", 32'({sec_tick, min_tick, hour_tick, day_tick}),
            32'({m.st, m.mt, m.ht, m.dt}));
      check("handshake", 32'({set_ready, set_done, set_error}), 32'({!m.pend, m.done, m.err}));
   end

   task automatic drive_set(input int h, input int mi, input int s, input int d);
      set_valid  = 1'b1;
      set_hour   = 5'(h);
      set_minute = 6'(mi);
      set_second = 6'(s);
      set_day    = 3'(d);
   endtask

   initial begin
      enable = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      repeat (13) @(negedge clk);
      check("run_3s", 32'(second), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_time", 32'({hour, minute, second, day_of_week}), 32'd0);
      check("async_rst_flags", 32'({set_ready, sec_tick, set_done, set_error}), 32'b1000);
      @(negedge clk);
      rst_n = 1'b1;

      repeat (4) @(negedge clk);
      check("first_sec", 32'({second, sec_tick}), 32'({6'd1, 1'b1}));
      @(negedge clk);
      check("sec_pulse_len", 32'(sec_tick), 32'd0);
      repeat (235) @(negedge clk);
      check("first_min", 32'({minute, second, sec_tick, min_tick}),
            32'({6'd1, 6'd0, 1'b1, 1'b1}));

      drive_set(23, 59, 58, 6);
      @(negedge clk);
      check("apply_not_ready", 32'(set_ready), 32'd0);
      set_valid = 1'b0;
      @(negedge clk);
      check("set_done", 32'({set_done, set_error, hour, minute, second, day_of_week}),
            32'({1'b1, 1'b0, 5'd23, 6'd59, 6'd58, 3'd6}));
      repeat (8) @(negedge clk);
      check("day_roll", 32'({hour, minute, second, day_of_week,
                             sec_tick, min_tick, hour_tick, day_tick}),
            32'({5'd0, 6'd0, 6'd0, 3'd0, 4'b1111}));

      drive_set(24, 10, 0, 0);
      @(negedge clk);
      set_valid = 1'b0;
      @(negedge clk);
      check("set_error", 32'({set_error, set_done, hour, minute, second}),
            32'({1'b1, 1'b0, 5'd0, 6'd0, 6'd0}));
      repeat (3) @(negedge clk);
      check("phase_kept", 32'({second, sec_tick}), 32'({6'd1, 1'b1}));

      repeat (2) @(negedge clk);
      enable = 1'b0;
      repeat (10) @(negedge clk);
      check("frozen", 32'({second, sec_tick}), 32'({6'd1, 1'b0}));
      enable = 1'b1;
      @(negedge clk);
      check("resume_1", 32'(sec_tick), 32'd0);
      @(negedge clk);
      check("resume_2", 32'({second, sec_tick}), 32'({6'd2, 1'b1}));

      repeat (3) @(negedge clk);
      drive_set(10, 0, 0, 2);
      @(negedge clk);
      check("capture_tick", 32'({sec_tick, set_ready, second}), 32'({1'b1, 1'b0, 6'd3}));
      set_valid = 1'b0;
      @(negedge clk);
      check("load_10", 32'({set_done, hour, minute, second, day_of_week, sec_tick}),
            32'({1'b1, 5'd10, 6'd0, 6'd0, 3'd2, 1'b0}));
      repeat (4) @(negedge clk);
      check("after_load_tick", 32'({second, sec_tick}), 32'({6'd1, 1'b1}));

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         enable    = ($urandom_range(0, 9) != 0);
         set_valid = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 3) == 0) begin
            set_hour   = 5'($urandom_range(0, 31));
            set_minute = 6'($urandom_range(0, 63));
            set_second = 6'($urandom_range(0, 63));
            set_day    = 3'($urandom_range(0, 7));
         end else if ($urandom_range(0, 1) == 0) begin
            set_hour   = 5'(23);
            set_minute = 6'(59);
            set_second = 6'($urandom_range(55, 59));
            set_day    = 3'($urandom_range(0, 6));
         end else begin
            set_hour   = 5'($urandom_range(0, 23));
            set_minute = 6'($urandom_range(57, 59));
            set_second = 6'($urandom_range(50, 59));
            set_day    = 3'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
      end
      set_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
